// File: rtl/keeper_screen_draw_pkg.sv
// Shared VGA definitions for the keeper-screen draw stage: timing bus, RGB444 channel, fade FSM states.
package keeper_screen_draw_pkg;

  localparam int CNT_W   = 11;
  localparam int CH_W    = 4;
  localparam int LVL_W   = 5;
  localparam int LVL_MAX = 16;

  typedef enum logic [1:0] {FADE_IDLE, FADE_RUN, FADE_SHOWN} fade_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount;
    logic             vsync;
    logic             vblnk;
    logic             hsync;
    logic             hblnk;
  } vga_bus_t;

  // (ch * level) >> 4, truncated back to one channel; level 16 is identity
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                input logic [LVL_W-1:0] lvl);
    logic [8:0] p;
    p = 9'(ch) * 9'(lvl);
    return p[7:4];
  endfunction

endpackage

// File: rtl/keeper_screen_draw_fade_ctrl.sv
// Frame-based fade-in controller: counts vsync rising edges from 0 to 16 while enabled.
// Only built when KEEPER_FADE_EN is defined.
`ifdef KEEPER_FADE_EN
module keeper_screen_draw_fade_ctrl
  import keeper_screen_draw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             vsync_in,
  output logic [LVL_W-1:0] level,
  output logic             fade_done
);

  fade_state_e      state_q;
  logic [LVL_W-1:0] level_q;
  logic             fade_done_q;
  logic             vs_q;
  logic             vs_edge;

  assign vs_edge   = vsync_in & ~vs_q;
  assign level     = level_q;
  assign fade_done = fade_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FADE_IDLE;
      level_q     <= '0;
      fade_done_q <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      if (!enable) begin
        state_q     <= FADE_IDLE;
        level_q     <= '0;
        fade_done_q <= 1'b0;
      end else begin
        case (state_q)
          // the edge coinciding with enable rising is deliberately dropped
          FADE_IDLE: state_q <= FADE_RUN;
          FADE_RUN: if (vs_edge) begin
            level_q <= level_q + 5'd1;
            if (level_q == 5'(LVL_MAX - 1)) begin
              state_q     <= FADE_SHOWN;
              fade_done_q <= 1'b1;
            end
          end
          FADE_SHOWN: begin
            level_q     <= 5'(LVL_MAX);
            fade_done_q <= 1'b1;
          end
          default: begin
            state_q     <= FADE_IDLE;
            level_q     <= '0;
            fade_done_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`endif

// File: rtl/keeper_screen_draw.sv
// Keeper-screen draw stage: ROM address generation, 3-cycle timing pipeline, optional fade-in.
// Define KEEPER_FADE_EN to build the fade FSM and per-channel scaling.
module keeper_screen_draw
  import keeper_screen_draw_pkg::*;
#(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 768,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      vcount_in,
  input  logic [CNT_W-1:0]      hcount_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  input  logic [DATA_WIDTH-1:0] rgb_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [CNT_W-1:0]      vcount_out,
  output logic [CNT_W-1:0]      hcount_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out,
  output logic                  fade_done
);

  localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_HEIGHT);

  vga_bus_t              bus_in, bus1_q, bus2_q, bus3_q;
  logic                  inside_d, in1_q, in2_q, en1_q, en2_q;
  logic [ADDR_WIDTH-1:0] rom_addr_d, rom_addr_q;
  logic [DATA_WIDTH-1:0] rgb1_q, rgb2_q, rgb_out_d, rgb_out_q;
  logic [DATA_WIDTH-1:0] pix;

  assign bus_in = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                    vblnk: vblnk_in, hsync: hsync_in, hblnk: hblnk_in};

`ifdef KEEPER_FADE_EN
  logic [LVL_W-1:0] level;

  keeper_screen_draw_fade_ctrl u_fade (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .vsync_in  (vsync_in),
    .level     (level),
    .fade_done (fade_done)
  );

  assign pix = {scale_ch(rom_data[11:8], level),
                scale_ch(rom_data[7:4],  level),
                scale_ch(rom_data[3:0],  level)};
`else
  logic fade_done_q;

  // without fading, "done" simply tracks enable through the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fade_done_q <= 1'b0;
    else        fade_done_q <= en2_q;
  end

  assign fade_done = fade_done_q;
  assign pix       = rom_data;
`endif

  always_comb begin
    inside_d   = (hcount_in < IMG_W_C) && (vcount_in < IMG_H_C);
    rom_addr_d = '0;
    if (enable && inside_d) rom_addr_d = ADDR_WIDTH'({vcount_in[9:0], hcount_in[9:0]});
  end

  always_comb begin
    rgb_out_d = pix;
    if (bus2_q.hblnk || bus2_q.vblnk) rgb_out_d = '0;
    else if (!en2_q || !in2_q)        rgb_out_d = rgb2_q;
  end

  // stage 1 issues the ROM read, stage 2 waits out ROM latency, stage 3 registers outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      bus1_q     <= '0;
      bus2_q     <= '0;
      bus3_q     <= '0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
      rgb_out_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      bus1_q     <= bus_in;
      en1_q      <= enable;
      in1_q      <= inside_d;
      rgb1_q     <= rgb_in;
      bus2_q     <= bus1_q;
      en2_q      <= en1_q;
      in2_q      <= in1_q;
      rgb2_q     <= rgb1_q;
      bus3_q     <= bus2_q;
      rgb_out_q  <= rgb_out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign vcount_out = bus3_q.vcount;
  assign hcount_out = bus3_q.hcount;
  assign vsync_out  = bus3_q.vsync;
  assign vblnk_out  = bus3_q.vblnk;
  assign hsync_out  = bus3_q.hsync;
  assign hblnk_out  = bus3_q.hblnk;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_keeper_screen_draw.sv
// Bench for keeper_screen_draw: directed test-plan points plus randomized traffic against a frame-level model.
module tb_keeper_screen_draw;

  localparam int NH = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [19:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        fade_done;

  logic        rom_mode = 1'b1;
  logic [11:0] rom_const = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keeper_screen_draw dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_data(rom_data),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .fade_done(fade_done)
  );

  function automatic logic [11:0] romf(input logic mode, input logic [11:0] c, input logic [19:0] a);
    return mode ? c : (a[11:0] ^ {a[19:12], a[3:0]} ^ 12'h5A5);
  endfunction

  // synchronous ROM, one cycle of read latency
  always @(posedge clk) rom_data <= romf(rom_mode, rom_const, rom_addr);

  typedef struct {
    bit          rst, en, vs, vb, hs, hb, mode, fd;
    logic [10:0] h, v;
    logic [11:0] rgb, rc;
    int          lvl;
  } snap_t;

  snap_t hist[NH];
  int    n = 0;

  // fade model: frames counted since the cycle after enable went high, saturating at 16
  bit armed = 0;
  int frames = 0;
  bit vs_prev = 0;

  always @(posedge clk) begin
    snap_t s;
    bit    vedge;
    s.rst = rst_n; s.en = enable; s.vs = vsync_in; s.vb = vblnk_in; s.hs = hsync_in;
    s.hb = hblnk_in; s.mode = rom_mode; s.rc = rom_const; s.h = hcount_in; s.v = vcount_in;
    s.rgb = rgb_in;
    s.lvl = frames;
    if (!rst_n) begin
      armed = 0; frames = 0; vs_prev = 0;
    end else begin
      vedge = vsync_in && !vs_prev;
      vs_prev = vsync_in;
      if (!enable) begin armed = 0; frames = 0; end
      else if (!armed) armed = 1;
      else if (vedge && frames < 16) frames++;
    end
    s.fd = armed && frames >= 16;
    if (n < NH) hist[n] = s;
    n++;
  end

  function automatic bit valid(input int k);
    return k >= 0 && k < NH && hist[k].rst;
  endfunction

  function automatic logic [19:0] addr_of(input snap_t s);
    return (s.en && s.h < 11'd1024 && s.v < 11'd768) ? {s.v[9:0], s.h[9:0]} : 20'h0;
  endfunction

  function automatic logic [11:0] scale(input logic [11:0] p, input int lvl);
    logic [11:0] r;
    for (int c = 0; c < 3; c++) r[c*4 +: 4] = 4'(((int'(p[c*4 +: 4]) * lvl) / 16) % 16);
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    int          e;
    bit          zero;
    snap_t       s;
    logic [19:0] ea;
    logic [11:0] ergb;
    logic [25:0] etim;
    logic        efd;
    int          lvl;
    e = n - 1;
    if (e >= 0 && e < NH) begin
      zero = !rst_n || !(valid(e) && valid(e-1) && valid(e-2));
      ea = (!rst_n || !valid(e)) ? 20'h0 : addr_of(hist[e]);
      ergb = '0; etim = '0; efd = 1'b0;
      if (!zero) begin
        s = hist[e-2];
`ifdef KEEPER_FADE_EN
        lvl = hist[e].lvl;
        efd = hist[e].fd;
`else
        lvl = 16;
        efd = s.en;
`endif
        if (s.vb || s.hb) ergb = '0;
        else if (addr_of(s) == 20'h0 && !(s.en && s.h == 0 && s.v == 0)) ergb = s.rgb;
        else ergb = scale(romf(hist[e-1].mode, hist[e-1].rc, addr_of(s)), lvl);
        etim = {s.v, s.h, s.vs, s.vb, s.hs, s.hb};
      end
`ifdef KEEPER_FADE_EN
      else if (rst_n && valid(e)) efd = hist[e].fd;
`endif
      cmp("rom_addr", 32'(rom_addr), 32'(ea));
      cmp("rgb_out", 32'(rgb_out), 32'(ergb));
      cmp("timing_out", 32'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out}), 32'(etim));
      cmp("fade_done", 32'(fade_done), 32'(efd));
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_vs(input int k);
    repeat (k) begin vsync_in = 1'b1; tick(2); vsync_in = 1'b0; tick(2); end
  endtask

  initial begin
    tick(3);
    cmp("reset_rom_addr", 32'(rom_addr), 32'h0);
    cmp("reset_rgb_out", 32'(rgb_out), 32'h0);
    cmp("reset_fade_done", 32'(fade_done), 32'h0);
    rst_n = 1'b1;
    tick(2);

`ifdef KEEPER_FADE_EN
    enable = 1'b1; hcount_in = 11'd5; vcount_in = 11'd3; rom_const = 12'hFFF;
    tick(3);
    pulse_vs(8); tick(3);
    cmp("fade_lvl8_rgb", 32'(rgb_out), 32'h777);
    cmp("fade_lvl8_done", 32'(fade_done), 32'h0);
    pulse_vs(8); tick(3);
    cmp("fade_full_rgb", 32'(rgb_out), 32'hFFF);
    cmp("fade_full_done", 32'(fade_done), 32'h1);
`else
    enable = 1'b1; hcount_in = 11'd5; vcount_in = 11'd3; rom_const = 12'h5A3;
    tick(2);
    cmp("nofade_done_t2", 32'(fade_done), 32'h0);
    tick(1);
    cmp("nofade_done_t3", 32'(fade_done), 32'h1);
    cmp("nofade_rgb", 32'(rgb_out), 32'h5A3);
`endif

    hcount_in = 11'd5; vcount_in = 11'd3; rom_const = 12'hABC;
    tick(1);
    cmp("addr_gen", 32'(rom_addr), 32'h00C05);
    tick(2);
    cmp("addr_rgb", 32'(rgb_out), 32'hABC);

    hcount_in = 11'd1030; vcount_in = 11'd100; rgb_in = 12'h123;
    tick(1);
    cmp("outside_addr", 32'(rom_addr), 32'h0);
    tick(2);
    cmp("outside_rgb", 32'(rgb_out), 32'h123);

    hcount_in = 11'd5; vcount_in = 11'd3; hblnk_in = 1'b1; hsync_in = 1'b1; rom_const = 12'hFFF;
    tick(3);
    cmp("blank_rgb", 32'(rgb_out), 32'h000);
    cmp("blank_hblnk", 32'(hblnk_out), 32'h1);
    cmp("blank_hsync", 32'(hsync_out), 32'h1);
    hblnk_in = 1'b0; hsync_in = 1'b0;

`ifdef KEEPER_FADE_EN
    enable = 1'b0;
    tick(1);
    cmp("drop_en_done", 32'(fade_done), 32'h0);
    tick(2);
    enable = 1'b1; tick(2);
    pulse_vs(10); tick(3);
    cmp("lvl10_rgb", 32'(rgb_out), 32'h999);
    rst_n = 1'b0; #1;
    cmp("midreset_rgb", 32'(rgb_out), 32'h0);
    cmp("midreset_addr", 32'(rom_addr), 32'h0);
    cmp("midreset_done", 32'(fade_done), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    cmp("refade_lvl0", 32'(rgb_out), 32'h000);
    pulse_vs(2); tick(3);
    cmp("refade_lvl2", 32'(rgb_out), 32'h111);
`endif

    rom_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = 1'b0;
      else if ($urandom_range(0, 9) == 0) enable = 1'b1;
      vsync_in  = ($urandom_range(0, 3) == 0);
      hcount_in = 11'($urandom_range(0, 1100));
      vcount_in = 11'($urandom_range(0, 820));
      hblnk_in  = ($urandom_range(0, 7) == 0);
      vblnk_in  = ($urandom_range(0, 15) == 0);
      hsync_in  = 1'($urandom);
      rgb_in    = 12'($urandom);
      if ($urandom_range(0, 19) == 0) begin rom_mode = 1'b1; rom_const = 12'($urandom); end
      else rom_mode = 1'b0;
      if ($urandom_range(0, 499) == 0) begin rst_n = 1'b0; tick(1); rst_n = 1'b1; end
      tick(1);
    end

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
